// File: rtl/mod4591_pkg.sv
// Shared constants, FSM encoding and the exact Barrett reduction for the q = 4591 field.
// Barrett with k = 26 leaves a remainder below 2q, so a single conditional subtract makes it exact.
package mod4591_pkg;

  localparam int Q         = 4591;
  localparam int COEF_W    = 13;
  localparam int EXP_BITS  = 13;
  localparam int IDX_W     = 4;
  localparam int PROD_W    = 26;
  localparam int BARRETT_K = 26;
  localparam int BARRETT_M = 14617;  // floor(2^26 / 4591)

  localparam logic [EXP_BITS-1:0] EXP = 13'h11ED;  // q - 2

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SQR,
    ST_MUL,
    ST_DONE
  } state_e;

  // x < 2^26 -> x mod 4591
  function automatic logic [COEF_W-1:0] barrett_reduce(input logic [PROD_W-1:0] x);
    logic [13:0]       q_est;
    logic [PROD_W-1:0] r;
    q_est = 14'((40'(x) * 40'(BARRETT_M)) >> BARRETT_K);
    r     = x - 26'(q_est) * 26'(Q);
    if (r >= 26'(Q)) begin
      r = r - 26'(Q);
    end
    return COEF_W'(r);
  endfunction

endpackage

// File: rtl/mod4591_mul.sv
// Combinational modular multiplier: p = a*b mod 4591 for a, b in 0..4590.
// Single cycle, no state; shared between the squaring and multiply steps.
module mod4591_mul
  import mod4591_pkg::*;
(
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [COEF_W-1:0] p
);

  logic [PROD_W-1:0] prod;

  assign prod = 26'(a) * 26'(b);
  assign p    = barrett_reduce(prod);

endmodule

// File: rtl/mod4591_inverse.sv
// Fermat inverse mod 4591: Out = In^4589, MSB-first square-and-multiply, one modmul per cycle.
// Fixed 27-cycle latency from capture to the Valid pulse; En is only honoured while idle.
module mod4591_inverse
  import mod4591_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] In,
  input  logic        En,
  output logic [15:0] Out,
  output logic        Valid
);

  state_e             state_q, state_d;
  logic [COEF_W-1:0]  acc_q, acc_d;
  logic [COEF_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        out_q, out_d;
  logic               valid_q, valid_d;

  logic [COEF_W-1:0]  in_red;
  logic [COEF_W-1:0]  mul_b;
  logic [COEF_W-1:0]  mul_p;

  assign in_red = barrett_reduce(26'(In));
  assign mul_b  = (state_q == ST_SQR) ? acc_q : base_q;

  mod4591_mul u_mul (
    .a (acc_q),
    .b (mul_b),
    .p (mul_p)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    idx_d   = idx_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (En) begin
          base_d  = in_red;
          acc_d   = COEF_W'(1);
          idx_d   = IDX_W'(EXP_BITS - 1);
          state_d = ST_SQR;
        end
      end
      ST_SQR: begin
        acc_d   = mul_p;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        // The multiply step always costs a cycle so latency stays data-independent.
        if (EXP[idx_q]) begin
          acc_d = mul_p;
        end
        if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = ST_SQR;
        end
      end
      ST_DONE: begin
        out_d   = {3'b000, acc_q};
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign Out   = out_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_mod4591_inverse.sv
// Bench for mod4591_inverse: constant vectors, back-to-back, mid-operation reset and a random sweep
// checked against a brute-force inverse search.
module tb_mod4591_inverse;

  localparam int Q   = 4591;
  localparam int LAT = 27;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b0;
  logic        En    = 1'b0;
  logic [15:0] In    = '0;
  logic [15:0] Out;
  logic        Valid;

  int n_pass  = 0;
  int n_total = 0;

  mod4591_inverse dut (
    .Clk   (Clk),
    .Reset (Reset),
    .In    (In),
    .En    (En),
    .Out   (Out),
    .Valid (Valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] in;
    int          exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inverse found by exhaustive search over the field; zero residue maps to zero.
  function automatic int ref_inv(input int x);
    int r;
    r = x % Q;
    if (r == 0) return 0;
    for (int y = 1; y < Q; y++) begin
      if ((r * y) % Q == 1) return y;
    end
    return -1;
  endfunction

  // One operation: capture, scramble inputs while busy, time the Valid pulse, check it is one cycle.
  task automatic run_op(input logic [15:0] val, output int res, output int lat);
    res = -1;
    lat = -1;
    @(negedge Clk);
    In = val;
    En = 1'b1;
    @(posedge Clk);
    #1;
    En = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clk);
      #1;
      if (Valid) begin
        lat = n;
        res = int'(Out);
        break;
      end
      In = 16'($urandom);
      En = 1'($urandom);
    end
    En = 1'b0;
    if (lat > 0) begin
      @(posedge Clk);
      #1;
      check("valid_one_cycle", int'(Valid), 0);
      check("out_holds", int'(Out), res);
    end
  endtask

  initial begin
    int res, lat, cnt, last_out, stable_err, val, r;
    int pulses[$];

    vecs[0] = '{16'd3,    3061};
    vecs[1] = '{16'd2,    2296};
    vecs[2] = '{16'd1,    1};
    vecs[3] = '{16'd4590, 4590};
    vecs[4] = '{16'd4594, 3061};
    vecs[5] = '{16'd0,    0};
    vecs[6] = '{16'd4591, 0};
    vecs[7] = '{16'd9182, 0};

    repeat (10) @(posedge Clk);
    @(negedge Clk);
    check("reset_out", int'(Out), 0);
    check("reset_valid", int'(Valid), 0);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].in, res, lat);
      check($sformatf("vec_out[in=%0d]", vecs[i].in), res, vecs[i].exp);
      check($sformatf("vec_lat[in=%0d]", vecs[i].in), lat, LAT);
    end

    // En held high: three back-to-back operations.
    pulses.delete();
    stable_err = 0;
    last_out   = 0;
    @(negedge Clk);
    In = 16'd5;
    En = 1'b1;
    @(posedge Clk);
    #1;
    for (int n = 1; n <= 120 && pulses.size() < 3; n++) begin
      @(posedge Clk);
      #1;
      if (Valid) begin
        pulses.push_back(n);
        check("b2b_result", int'(Out), ref_inv(5));
        last_out = int'(Out);
        if (pulses.size() == 3) En = 1'b0;
      end else if (pulses.size() > 0 && int'(Out) != last_out) begin
        stable_err++;
      end
    end
    En = 1'b0;
    check("b2b_pulse_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      check("b2b_first_lat", pulses[0], LAT);
      check("b2b_gap1", pulses[1] - pulses[0], 28);
      check("b2b_gap2", pulses[2] - pulses[1], 28);
    end
    check("b2b_out_stable", stable_err, 0);
    @(posedge Clk);
    #1;
    check("b2b_no_fourth", int'(Valid), 0);

    // Reset lands on capture edge + 10 and must abort the operation.
    @(negedge Clk);
    In = 16'd7;
    En = 1'b1;
    @(posedge Clk);
    #1;
    En = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("abort_out", int'(Out), 0);
    check("abort_valid", int'(Valid), 0);
    @(negedge Clk);
    Reset = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Valid) cnt++;
    end
    check("abort_no_pulse", cnt, 0);
    check("abort_out_after", int'(Out), 0);
    run_op(16'd3, res, lat);
    check("restart_out", res, 3061);
    check("restart_lat", lat, LAT);

    // Random sweep, mostly field elements with some full-range 16-bit operands.
    for (int i = 0; i < 50; i++) begin
      if (i < 40) val = int'($urandom_range(1, Q - 1));
      else        val = int'($urandom & 32'hFFFF);
      run_op(16'(val), res, lat);
      check($sformatf("rand_out[in=%0d]", val), res, ref_inv(val));
      check($sformatf("rand_lat[in=%0d]", val), lat, LAT);
      r = val % Q;
      if (r != 0) check($sformatf("rand_prod[in=%0d]", val), (r * res) % Q, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
